debounce_multi_channel: RTL and testbench

Parametrised multi-channel debouncer for mechanical switch and button inputs, fitted between the board-level GPIO pins and the user-logic register interface. Each channel has a configurable synchroniser depth, separate rising and falling qualification times, and a per-channel reset level. Each channel also produces registered one-cycle rise and fall event pulses, so downstream logic needs no edge detectors of its own. All channels run independently on a single clock.

---
 rtl/debounce_multi_channel.sv | 139 +++++++++++++
 tb/tb_debounce_multi_channel.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi_channel.sv
// debounce_multi_channel
// Multi-channel switch debouncer. Each channel synchronises its raw input,
// then qualifies every level change with a per-direction hold time before
// updating the debounced output and emitting a one-cycle rise/fall pulse.
// Channels are fully independent; any_event summarises all pulses of a cycle.

module debounce_multi_channel #(
    parameter int               WIDTH        = 8,
    parameter int               SYNC_STAGES  = 2,
    parameter int               RISE_TIMEOUT = 50000,
    parameter int               FALL_TIMEOUT = 50000,
    parameter logic [WIDTH-1:0] INIT_LEVEL   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_event
);

    localparam int MAX_T = (RISE_TIMEOUT > FALL_TIMEOUT) ? RISE_TIMEOUT : FALL_TIMEOUT;
    localparam int CNT_W = $clog2(MAX_T + 1);

    // Terminal counts: reaching T-1 while the new level still holds means
    // T+1 consecutive identical samples have been seen.
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(FALL_TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        QUAL = 1'b1
    } state_t;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s_level;
    logic [WIDTH-1:0] data_out_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;

    // Synchroniser chain: every stage resets to the channel's initial level
    // so a freshly reset channel sees no phantom transition.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= INIT_LEVEL;
            end
        end else begin
            sync_q[0] <= data_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s_level = sync_q[SYNC_STAGES-1];

    // Per-channel qualification FSM and counter.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_d;
        logic             rise_c;
        logic             fall_c;
        logic [CNT_W-1:0] last_cnt;

        // The hold time depends on the direction of the pending change,
        // which is fixed by the current debounced level.
        assign last_cnt = data_out[i] ? FALL_LAST : RISE_LAST;

        // State and counter register.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Next state: a differing sample opens a qualification window, any
        // matching sample inside it aborts, and reaching the terminal count
        // commits the new level together with its pulse.
        always_comb begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = data_out[i];
            rise_c  = 1'b0;
            fall_c  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (s_level[i] != data_out[i]) begin
                        state_d = QUAL;
                    end
                end
                QUAL: begin
                    if (s_level[i] == data_out[i]) begin
                        state_d = IDLE;
                    end else if (cnt_q == last_cnt) begin
                        level_d = s_level[i];
                        rise_c  = s_level[i];
                        fall_c  = ~s_level[i];
                    end else begin
                        state_d = QUAL;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        assign data_out_d[i] = level_d;
        assign rise_d[i]     = rise_c;
        assign fall_d[i]     = fall_c;
    end

    // Output registers: level, pulses and the summary event all update on
    // the same edge so downstream logic sees them aligned.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out   <= INIT_LEVEL;
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_event  <= 1'b0;
        end else begin
            data_out   <= data_out_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
            any_event  <= |(rise_d | fall_d);
        end
    end

endmodule

// File: tb/tb_debounce_multi_channel.sv
// tb_debounce_multi_channel
// Directed scenarios followed by a randomised phase. A run-length reference
// model predicts every output each cycle; key scenario points are also
// checked against fixed expected values.

module tb_debounce_multi_channel;

    localparam int         WIDTH       = 4;
    localparam int         SYNC_STAGES = 2;
    localparam int         RISE_T      = 4;
    localparam int         FALL_T      = 6;
    localparam logic [3:0] INIT        = 4'b1000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] data_in = 4'b0000;
    logic [3:0] data_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic       any_event;

    int compared = 0;
    int mismatched = 0;

    // Reference model state: input samples still travelling through the
    // synchroniser, the accepted level, and how many consecutive samples
    // have disagreed with that level.
    logic [3:0] m_hist [SYNC_STAGES];
    logic [3:0] m_out;
    logic [3:0] m_rise;
    logic [3:0] m_fall;
    logic       m_any;
    int         m_run [WIDTH];

    debounce_multi_channel #(
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (SYNC_STAGES),
        .RISE_TIMEOUT (RISE_T),
        .FALL_TIMEOUT (FALL_T),
        .INIT_LEVEL   (INIT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_out   (data_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_event  (any_event)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Advance the model by one rising edge with the inputs present there.
    task automatic modelStep(input logic rst_n, input logic [3:0] din);
        logic [3:0] s;
        int         needed;
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) m_hist[k] = INIT;
            m_out  = INIT;
            m_rise = 4'b0000;
            m_fall = 4'b0000;
            m_any  = 1'b0;
            for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
        end else begin
            s = m_hist[SYNC_STAGES-1];
            for (int k = SYNC_STAGES-1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = din;
            m_rise = 4'b0000;
            m_fall = 4'b0000;
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == m_out[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                    needed = (m_out[i] ? FALL_T : RISE_T) + 1;
                    if (m_run[i] == needed) begin
                        if (s[i]) m_rise[i] = 1'b1;
                        else      m_fall[i] = 1'b1;
                        m_out[i] = s[i];
                        m_run[i] = 0;
                    end
                end
            end
            m_any = |(m_rise | m_fall);
        end
    endtask

    task automatic checkOutput(input string tag);
        compared++;
        assert (data_out === m_out) else begin
            mismatched++;
            $error("[TB] FAIL %s data_out observed=%b expected=%b", tag, data_out, m_out);
        end
        compared++;
        assert (rise_pulse === m_rise) else begin
            mismatched++;
            $error("[TB] FAIL %s rise_pulse observed=%b expected=%b", tag, rise_pulse, m_rise);
        end
        compared++;
        assert (fall_pulse === m_fall) else begin
            mismatched++;
            $error("[TB] FAIL %s fall_pulse observed=%b expected=%b", tag, fall_pulse, m_fall);
        end
        compared++;
        assert (any_event === m_any) else begin
            mismatched++;
            $error("[TB] FAIL %s any_event observed=%b expected=%b", tag, any_event, m_any);
        end
    endtask

    task automatic checkOutputValue(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive inputs just after an edge, then step model and check each cycle.
    task automatic applyStimulus(input logic rst_n, input logic [3:0] din, input int cycles, input string tag);
        reset_n = rst_n;
        data_in = din;
        repeat (cycles) begin
            @(posedge clk);
            modelStep(rst_n, din);
            #1;
            checkOutput(tag);
        end
    endtask

    // Directed scenarios, then randomised traffic with occasional resets.
    initial begin
        $display("[TB] start");

        // Reset with inputs differing from the initial level.
        applyStimulus(1'b0, 4'b1010, 3, "reset");
        checkOutputValue("reset_out",  data_out,   4'b1000);
        checkOutputValue("reset_rise", rise_pulse, 4'b0000);
        checkOutputValue("reset_fall", fall_pulse, 4'b0000);
        checkOutputValue("reset_any",  {3'b000, any_event}, 4'b0000);
        applyStimulus(1'b1, 4'b1010, 6, "post_reset");
        checkOutputValue("post_reset_hold", data_out, 4'b1000);
        applyStimulus(1'b1, 4'b1010, 1, "post_reset");
        checkOutputValue("post_reset_out",  data_out,   4'b1010);
        checkOutputValue("post_reset_rise", rise_pulse, 4'b0010);

        // Clean rise on channel 0.
        applyStimulus(1'b1, 4'b1011, 6, "clean_rise");
        checkOutputValue("clean_rise_hold", data_out, 4'b1010);
        applyStimulus(1'b1, 4'b1011, 1, "clean_rise");
        checkOutputValue("clean_rise_out",  data_out,   4'b1011);
        checkOutputValue("clean_rise_puls", rise_pulse, 4'b0001);
        checkOutputValue("clean_rise_any",  {3'b000, any_event}, 4'b0001);
        applyStimulus(1'b1, 4'b1011, 1, "clean_rise");
        checkOutputValue("clean_rise_any_end", {3'b000, any_event}, 4'b0000);

        // Channel 2: four high cycles rejected, five accepted.
        applyStimulus(1'b1, 4'b1111, 4, "rise_reject");
        applyStimulus(1'b1, 4'b1011, 10, "rise_reject");
        checkOutputValue("rise_reject_out", data_out, 4'b1011);
        applyStimulus(1'b1, 4'b1111, 5, "rise_accept");
        applyStimulus(1'b1, 4'b1011, 1, "rise_accept");
        checkOutputValue("rise_accept_hold", data_out, 4'b1011);
        applyStimulus(1'b1, 4'b1011, 1, "rise_accept");
        checkOutputValue("rise_accept_out",  data_out,   4'b1111);
        checkOutputValue("rise_accept_puls", rise_pulse, 4'b0100);
        applyStimulus(1'b1, 4'b1011, 12, "settle");
        checkOutputValue("settle_out", data_out, 4'b1011);

        // Channel 3: six low cycles rejected, seven accepted.
        applyStimulus(1'b1, 4'b0011, 6, "fall_reject");
        applyStimulus(1'b1, 4'b1011, 10, "fall_reject");
        checkOutputValue("fall_reject_out", data_out, 4'b1011);
        applyStimulus(1'b1, 4'b0011, 7, "fall_accept");
        applyStimulus(1'b1, 4'b1011, 1, "fall_accept");
        checkOutputValue("fall_accept_hold", data_out, 4'b1011);
        applyStimulus(1'b1, 4'b1011, 1, "fall_accept");
        checkOutputValue("fall_accept_out",  data_out,   4'b0011);
        checkOutputValue("fall_accept_puls", fall_pulse, 4'b1000);
        applyStimulus(1'b1, 4'b1011, 12, "settle");

        // Channels 0 and 1 together, then reset in the middle of a fall.
        applyStimulus(1'b1, 4'b1000, 12, "simul_prep");
        checkOutputValue("simul_prep_out", data_out, 4'b1000);
        applyStimulus(1'b1, 4'b1011, 6, "simul");
        applyStimulus(1'b1, 4'b1011, 1, "simul");
        checkOutputValue("simul_out",  data_out,   4'b1011);
        checkOutputValue("simul_rise", rise_pulse, 4'b0011);
        checkOutputValue("simul_any",  {3'b000, any_event}, 4'b0001);
        applyStimulus(1'b1, 4'b1011, 1, "simul");
        checkOutputValue("simul_any_end", {3'b000, any_event}, 4'b0000);
        applyStimulus(1'b1, 4'b1010, 3, "mid_reset");
        applyStimulus(1'b0, 4'b1010, 2, "mid_reset");
        checkOutputValue("mid_reset_out",  data_out,   4'b1000);
        checkOutputValue("mid_reset_fall", fall_pulse, 4'b0000);
        applyStimulus(1'b1, 4'b1010, 10, "mid_reset_rel");
        checkOutputValue("mid_reset_rel_out", data_out, 4'b1010);

        // Randomised bouncing with occasional resets.
        for (int n = 0; n < 150; n++) begin
            applyStimulus(($urandom_range(0, 40) != 0) ? 1'b1 : 1'b0,
                          4'($urandom_range(0, 15)),
                          int'($urandom_range(1, 9)),
                          "random");
        end
        applyStimulus(1'b1, data_in, 12, "random_tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
